// File: rtl/ram128_arbiter.sv
// Sequencer and round-robin arbiter for a 128-deep single-port distributed RAM bank.
// Clears the bank after reset, then shares it between two requesters with registered read return.
module ram128_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter bit          INIT_CLEAR = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_a,
    input  logic                  we_a,
    input  logic [6:0]            addr_a,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    output logic                  gnt_a,
    output logic                  rvalid_a,
    output logic [DATA_WIDTH-1:0] rdata_a,
    input  logic                  req_b,
    input  logic                  we_b,
    input  logic [6:0]            addr_b,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    output logic                  gnt_b,
    output logic                  rvalid_b,
    output logic [DATA_WIDTH-1:0] rdata_b,
    output logic [6:0]            ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_d,
    input  logic [DATA_WIDTH-1:0] ram_o,
    output logic                  busy
);

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    localparam state_t RST_STATE = INIT_CLEAR ? ST_CLEAR : ST_IDLE;

    state_t                r_state;
    logic [6:0]            r_clr_cnt;
    logic                  r_last_b;
    logic [6:0]            r_ram_addr;
    logic                  r_ram_we;
    logic [DATA_WIDTH-1:0] r_ram_d;
    logic                  r_gnt_a;
    logic                  r_gnt_b;
    logic                  r_rvalid_a;
    logic                  r_rvalid_b;
    logic [DATA_WIDTH-1:0] r_rdata_a;
    logic [DATA_WIDTH-1:0] r_rdata_b;

    state_t                w_state_n;
    logic [6:0]            w_clr_cnt_n;
    logic                  w_last_b_n;
    logic [6:0]            w_ram_addr_n;
    logic                  w_ram_we_n;
    logic [DATA_WIDTH-1:0] w_ram_d_n;
    logic                  w_gnt_a_n;
    logic                  w_gnt_b_n;
    logic                  w_rvalid_a_n;
    logic                  w_rvalid_b_n;
    logic [DATA_WIDTH-1:0] w_rdata_a_n;
    logic [DATA_WIDTH-1:0] w_rdata_b_n;
    logic                  w_elig_a;
    logic                  w_elig_b;
    logic                  w_pick_a;
    logic                  w_pick_b;

    // A port granted this cycle sits out the next edge so a still-held req is not served twice.
    assign w_elig_a = req_a & ~r_gnt_a;
    assign w_elig_b = req_b & ~r_gnt_b;
    assign w_pick_a = w_elig_a & (~w_elig_b | r_last_b);
    assign w_pick_b = w_elig_b & ~w_pick_a;

    always_comb begin
        w_state_n    = r_state;
        w_clr_cnt_n  = r_clr_cnt;
        w_last_b_n   = r_last_b;
        w_ram_addr_n = r_ram_addr;
        w_ram_we_n   = 1'b0;
        w_ram_d_n    = r_ram_d;
        w_gnt_a_n    = 1'b0;
        w_gnt_b_n    = 1'b0;
        // The granted read's address is on the bank during the grant cycle; capture it at its end.
        w_rvalid_a_n = r_gnt_a & ~r_ram_we;
        w_rvalid_b_n = r_gnt_b & ~r_ram_we;
        w_rdata_a_n  = w_rvalid_a_n ? ram_o : r_rdata_a;
        w_rdata_b_n  = w_rvalid_b_n ? ram_o : r_rdata_b;

        case (r_state)
            ST_CLEAR: begin
                if (r_ram_we && (r_ram_addr == 7'd127)) begin
                    w_state_n = ST_IDLE;
                end else begin
                    w_ram_we_n   = 1'b1;
                    w_ram_d_n    = '0;
                    w_ram_addr_n = r_clr_cnt;
                    w_clr_cnt_n  = r_clr_cnt + 7'd1;
                end
            end
            ST_IDLE: begin
                if (w_pick_a) begin
                    w_gnt_a_n    = 1'b1;
                    w_ram_addr_n = addr_a;
                    w_ram_we_n   = we_a;
                    w_ram_d_n    = wdata_a;
                    w_last_b_n   = 1'b0;
                end else if (w_pick_b) begin
                    w_gnt_b_n    = 1'b1;
                    w_ram_addr_n = addr_b;
                    w_ram_we_n   = we_b;
                    w_ram_d_n    = wdata_b;
                    w_last_b_n   = 1'b1;
                end
            end
            default: w_state_n = RST_STATE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= RST_STATE;
            r_clr_cnt  <= '0;
            r_last_b   <= 1'b1;
            r_ram_addr <= '0;
            r_ram_we   <= 1'b0;
            r_ram_d    <= '0;
            r_gnt_a    <= 1'b0;
            r_gnt_b    <= 1'b0;
            r_rvalid_a <= 1'b0;
            r_rvalid_b <= 1'b0;
            r_rdata_a  <= '0;
            r_rdata_b  <= '0;
        end else begin
            r_state    <= w_state_n;
            r_clr_cnt  <= w_clr_cnt_n;
            r_last_b   <= w_last_b_n;
            r_ram_addr <= w_ram_addr_n;
            r_ram_we   <= w_ram_we_n;
            r_ram_d    <= w_ram_d_n;
            r_gnt_a    <= w_gnt_a_n;
            r_gnt_b    <= w_gnt_b_n;
            r_rvalid_a <= w_rvalid_a_n;
            r_rvalid_b <= w_rvalid_b_n;
            r_rdata_a  <= w_rdata_a_n;
            r_rdata_b  <= w_rdata_b_n;
        end
    end

    assign ram_addr = r_ram_addr;
    assign ram_we   = r_ram_we;
    assign ram_d    = r_ram_d;
    assign gnt_a    = r_gnt_a;
    assign gnt_b    = r_gnt_b;
    assign rvalid_a = r_rvalid_a;
    assign rvalid_b = r_rvalid_b;
    assign rdata_a  = r_rdata_a;
    assign rdata_b  = r_rdata_b;
    assign busy     = (r_state == ST_CLEAR);

endmodule

// File: tb/tb_ram128_arbiter.sv
// Directed self-checking bench for ram128_arbiter, with a behavioural falling-edge-write RAM bank.
module tb_ram128_arbiter;

    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
    logic [6:0]    addr_a = '0, addr_b = '0;
    logic [DW-1:0] wdata_a = '0, wdata_b = '0;
    logic          gnt_a, rvalid_a, gnt_b, rvalid_b, ram_we, busy;
    logic [DW-1:0] rdata_a, rdata_b, ram_d, ram_o;
    logic [6:0]    ram_addr;

    int n_checks = 0;
    int n_pass   = 0;

    // Unwritten locations read as 0xFF so the clear sequence is observable.
    logic [DW-1:0] mem [128];
    logic [127:0]  written = '0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ram_we) begin
            mem[ram_addr]     <= ram_d;
            written[ram_addr] <= 1'b1;
        end
    end

    assign ram_o = written[ram_addr] ? mem[ram_addr] : 8'hFF;

    ram128_arbiter #(.DATA_WIDTH(DW), .INIT_CLEAR(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_d(ram_d), .ram_o(ram_o),
        .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs n clear cycles, expecting ram_addr 0..n-1 with we=1, d=0, busy and no grants/rvalids.
    task automatic run_clear(input int n, input string name);
        int bad = 0;
        int first_bad = -1;
        for (int i = 0; i < n; i++) begin
            tick();
            if (ram_we !== 1'b1 || ram_addr !== 7'(i) || ram_d !== '0 || busy !== 1'b1 ||
                gnt_a !== 1'b0 || gnt_b !== 1'b0 || rvalid_a !== 1'b0 || rvalid_b !== 1'b0) begin
                if (first_bad < 0) first_bad = i;
                bad++;
            end
        end
        n_checks++;
        if (bad != 0)
            $display("FAIL %s: %0d bad cycles (first at %0d, addr=%0d we=%0b busy=%0b) required 0",
                     name, bad, first_bad, ram_addr, ram_we, busy);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({busy, ram_we, gnt_a, gnt_b, rvalid_a, rvalid_b} !== 6'b100000)
            $display("FAIL reset_ctrl: got %b required 100000", {busy, ram_we, gnt_a, gnt_b, rvalid_a, rvalid_b});
        else n_pass++;
        n_checks++;
        if ({ram_addr, ram_d, rdata_a, rdata_b} !== '0)
            $display("FAIL reset_data: got addr=%0h d=%0h ra=%0h rb=%0h required all 0", ram_addr, ram_d, rdata_a, rdata_b);
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_clear();
        int nz = 0;
        req_a = 1'b1; we_a = 1'b0; addr_a = 7'h55;
        run_clear(128, "clear_seq");
        tick();
        n_checks++;
        if ({busy, ram_we, gnt_a} !== 3'b000)
            $display("FAIL clear_done: got busy/we/gnt_a=%b required 000", {busy, ram_we, gnt_a});
        else n_pass++;
        for (int i = 0; i < 128; i++) if (!written[i] || mem[i] !== '0) nz++;
        n_checks++;
        if (nz != 0) $display("FAIL clear_bank: got %0d uncleared words required 0", nz);
        else n_pass++;
        tick();
        n_checks++;
        if ({gnt_a, ram_we, ram_addr} !== {1'b1, 1'b0, 7'h55})
            $display("FAIL held_req_gnt: got gnt=%0b we=%0b addr=%0h required 1 0 55", gnt_a, ram_we, ram_addr);
        else n_pass++;
        req_a = 1'b0;
        tick();
        n_checks++;
        if ({rvalid_a, rdata_a} !== {1'b1, 8'h00})
            $display("FAIL read_cleared: got rvalid=%0b rdata=%0h required 1 00", rvalid_a, rdata_a);
        else n_pass++;
    endtask

    task automatic test_write_read();
        req_a = 1'b1; we_a = 1'b1; addr_a = 7'h10; wdata_a = 8'hA5;
        tick();
        n_checks++;
        if ({gnt_a, ram_we, ram_addr, ram_d} !== {1'b1, 1'b1, 7'h10, 8'hA5})
            $display("FAIL wr_issue: got gnt=%0b we=%0b addr=%0h d=%0h required 1 1 10 a5", gnt_a, ram_we, ram_addr, ram_d);
        else n_pass++;
        we_a = 1'b0;
        tick();
        n_checks++;
        if ({gnt_a, rvalid_a, ram_we} !== 3'b000)
            $display("FAIL no_back_to_back: got gnt/rvalid/we=%b required 000", {gnt_a, rvalid_a, ram_we});
        else n_pass++;
        tick();
        n_checks++;
        if ({gnt_a, ram_we, ram_addr} !== {1'b1, 1'b0, 7'h10})
            $display("FAIL rd_issue: got gnt=%0b we=%0b addr=%0h required 1 0 10", gnt_a, ram_we, ram_addr);
        else n_pass++;
        req_a = 1'b0;
        tick();
        n_checks++;
        if ({rvalid_a, rdata_a} !== {1'b1, 8'hA5})
            $display("FAIL rd_data: got rvalid=%0b rdata=%0h required 1 a5", rvalid_a, rdata_a);
        else n_pass++;
        tick();
        n_checks++;
        if (rvalid_a !== 1'b0) $display("FAIL rvalid_pulse: got %0b required 0", rvalid_a);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        req_a = 1'b1; we_a = 1'b0; addr_a = 7'h10;
        tick();
        n_checks++;
        if (gnt_a !== 1'b1) $display("FAIL inflight_gnt: got %0b required 1", gnt_a);
        else n_pass++;
        req_a = 1'b0;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({gnt_a, busy, ram_we, rdata_a, ram_addr} !== {1'b0, 1'b1, 1'b0, 8'h00, 7'h00})
            $display("FAIL async_reset: got gnt=%0b busy=%0b we=%0b rdata=%0h addr=%0h required 0 1 0 00 00",
                     gnt_a, busy, ram_we, rdata_a, ram_addr);
        else n_pass++;
        tick();
        n_checks++;
        if (rvalid_a !== 1'b0) $display("FAIL inflight_rvalid: got %0b required 0", rvalid_a);
        else n_pass++;
        reset = 1'b0;
        run_clear(65, "clear_partial");
        reset = 1'b1;
        #1;
        n_checks++;
        if ({ram_addr, ram_we, busy} !== {7'h00, 1'b0, 1'b1})
            $display("FAIL reset_at_64: got addr=%0h we=%0b busy=%0b required 00 0 1", ram_addr, ram_we, busy);
        else n_pass++;
        tick();
        reset = 1'b0;
        run_clear(128, "clear_restart");
        tick();
        n_checks++;
        if ({busy, ram_we} !== 2'b00) $display("FAIL restart_done: got busy/we=%b required 00", {busy, ram_we});
        else n_pass++;
    endtask

    task automatic test_both_same_cycle();
        req_a = 1'b1; we_a = 1'b1; addr_a = 7'h20; wdata_a = 8'h3C;
        req_b = 1'b1; we_b = 1'b0; addr_b = 7'h20; wdata_b = 8'h00;
        tick();
        n_checks++;
        if ({gnt_a, gnt_b, ram_we, ram_addr} !== {1'b1, 1'b0, 1'b1, 7'h20})
            $display("FAIL tie_first: got gnt_a=%0b gnt_b=%0b we=%0b addr=%0h required 1 0 1 20", gnt_a, gnt_b, ram_we, ram_addr);
        else n_pass++;
        req_a = 1'b0;
        tick();
        n_checks++;
        if ({gnt_a, gnt_b, ram_we} !== 3'b010)
            $display("FAIL tie_second: got gnt_a/gnt_b/we=%b required 010", {gnt_a, gnt_b, ram_we});
        else n_pass++;
        req_b = 1'b0;
        tick();
        n_checks++;
        if ({rvalid_b, rdata_b, rvalid_a} !== {1'b1, 8'h3C, 1'b0})
            $display("FAIL raw_data: got rvalid_b=%0b rdata_b=%0h rvalid_a=%0b required 1 3c 0", rvalid_b, rdata_b, rvalid_a);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        req_a = 1'b1; we_a = 1'b0; addr_a = 7'h10;
        req_b = 1'b1; we_b = 1'b0; addr_b = 7'h20;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (gnt_a !== ((i % 2) == 0) || gnt_b !== ((i % 2) == 1)) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL alternate: got %0b/%0b at end, %0d bad cycles required 0", gnt_a, gnt_b, bad);
        else n_pass++;
        req_a = 1'b0; req_b = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({gnt_a, gnt_b} !== 2'b00) $display("FAIL alt_idle: got %b required 00", {gnt_a, gnt_b});
        else n_pass++;
    endtask

    task automatic test_b_only();
        int bad = 0;
        req_b = 1'b1; we_b = 1'b0; addr_b = 7'h20;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (gnt_b !== ((i % 2) == 0) || gnt_a !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL b_only: got %0d bad cycles required 0", bad);
        else n_pass++;
        req_b = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'hFF;
        test_reset();
        test_clear();
        test_write_read();
        test_reset_mid();
        test_both_same_cycle();
        test_back_to_back();
        test_b_only();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ram128_arbiter.md
Name: ram128_arbiter

Overview:
- Sequencing and arbitration controller for a 128-deep, DATA_WIDTH-wide single-port distributed RAM bank.
- The bank is built from per-bit 128x1 RAM primitives that write on the falling clock edge and read combinationally.
- After reset the block clears the bank, then shares it between two requesters (port A, port B) with round-robin arbitration.
- It drives the bank's shared address, write-enable and data, and returns registered read data to the requester.

Parameters:
- DATA_WIDTH, 8, width of each RAM word (one 128x1 primitive per bit).
- INIT_CLEAR, 1, 1 = write zero to all 128 locations after reset; 0 = skip the clear and go straight to IDLE.

Ports:
- clk  in  1  single system clock; the RAM bank is clocked by the same net and writes on its falling edge.
- reset  in  1  asynchronous, active-high reset.
- req_a  in  1  port A access request; held with we_a/addr_a/wdata_a stable until gnt_a is seen.
- we_a  in  1  port A: 1 = write, 0 = read.
- addr_a  in  7  port A word address.
- wdata_a  in  DATA_WIDTH  port A write data.
- gnt_a  out  1  one-cycle pulse: port A access is issued to the RAM this cycle.
- rvalid_a  out  1  one-cycle pulse: rdata_a holds port A read result.
- rdata_a  out  DATA_WIDTH  port A read data (holds its value between reads).
- req_b, we_b, addr_b, wdata_b, gnt_b, rvalid_b, rdata_b: same as port A, for port B.
- ram_addr  out  7  bank address (A6..A0 of every primitive).
- ram_we  out  1  bank write enable.
- ram_d  out  DATA_WIDTH  bank write data.
- ram_o  in  DATA_WIDTH  bank combinational read data.
- busy  out  1  high while the clear sequence runs; no grants are issued while high.

Behaviour:
- Clock and reset: all outputs are registered on the rising clk edge. Reset asynchronously forces:
  - ram_addr=0, ram_we=0, ram_d=0
  - gnt_*=0, rvalid_*=0, rdata_*=0
  - last-served pointer = B, so A wins the first tie
  - state = CLEAR if INIT_CLEAR=1 (busy=1), else IDLE (busy=0).
- State machine: CLEAR, IDLE.
- CLEAR:
  - Each cycle drives ram_we=1, ram_d=0, ram_addr=clear counter (0..127, incrementing by 1).
  - The cycle with ram_addr=127 is the last. At the following edge: state becomes IDLE, busy=0, ram_we=0.
  - The sequence takes exactly 128 cycles with ram_we=1. Requests are ignored (not lost: requesters keep req held).
- IDLE arbitration, evaluated at each rising edge:
  - A port is eligible if its req=1 and its gnt is currently 0. A port granted in cycle n cannot be granted at edge n+1, which prevents double service of a still-held req.
  - One eligible port: it wins.
  - Both eligible: the port not last served wins.
  - Winner: gnt_x=1 for one cycle; ram_addr/ram_we/ram_d loaded from that port's addr/we/wdata; last-served pointer updated.
  - No winner: ram_we=0; ram_addr and ram_d hold their values.
- Timing from a request sampled at edge n:
  - Cycle n+1: gnt pulse; the RAM write occurs at the falling edge mid-cycle n+1.
  - Read: rdata_x <= ram_o at edge n+1; rvalid_x=1 during cycle n+2. Read latency is 2 edges from sampling.
  - Write: no rvalid.
- Throughput:
  - One RAM access per cycle in total.
  - With both ports continuously requesting, grants alternate A,B,A,B.
  - A single port alone is served at most every other cycle.
- Same-address conflicts: accesses complete in grant order. A read granted the cycle after a write to the same address returns the new data.
- Reset mid-operation: an in-flight read produces no rvalid. The clear restarts from address 0 when INIT_CLEAR=1.

Test Plan:
- INIT_CLEAR=1, release reset -> busy=1 for exactly 128 cycles; ram_we=1 with ram_addr 0..127 in order, ram_d=0; then busy=0, ram_we=0. Subsequent read of addr 0x55 by A -> rdata_a=0x00.
- After clear, A writes 0xA5 to 0x10, then reads 0x10 -> gnt_a one cycle after each sampled req; rvalid_a two edges after read req sampled; rdata_a=0xA5.
- req_a and req_b asserted the same cycle (A write 0x3C@0x20, B read 0x20) -> gnt_a first (pointer reset to B), gnt_b next cycle, rdata_b=0x3C.
- Both ports hold req continuously for 10 cycles -> grants strictly alternate A,B,A,B… with one grant per cycle and no port granted twice consecutively.
- Only req_b held continuously -> gnt_b pulses every other cycle, never two consecutive cycles.
- Assert reset for one cycle while a read is in flight and again during clear at address 64 -> all outputs return to reset values immediately, no rvalid pulse, clear restarts at address 0 and runs the full 128 cycles.
